// File: rtl/handshake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_pkg
//  Description : Types and constants shared by the handshake arbiter files.
//                Holds the arbiter state encoding, the default handshake
//                data width and a helper that sizes the timeout counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package handshake_pkg;

   localparam int HS_WIDTH = 32;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;

   // Width needed to count from 0 up to limit-1; never narrower than one bit.
   function automatic int cnt_width(input int limit);
      int w;
      w = $clog2(limit);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/handshake.sv
`default_nettype none
// ============================================================================
//  Module      : handshake
//  Description : Two-word handshake bundle. port1 travels one way and port2
//                the other way; the modports name the two sides.
//                  dir1 : drives port1, receives port2
//                  dir2 : receives port1, drives port2
//  Revision    : 1.0 - initial release
// ============================================================================
interface handshake
   import handshake_pkg::*;
#(
   parameter int WIDTH = HS_WIDTH
);
   logic [WIDTH-1:0] port1;
   logic [WIDTH-1:0] port2;

   modport dir1 (output port1, input port2);
   modport dir2 (input port1, output port2);
endinterface
`default_nettype wire

// File: rtl/handshake_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Round-robin selector. Scans the request vector upward from
//                the pointer, wrapping modulo NUM_REQ, and reports the first
//                active requester as a one-hot grant and as an index.
//  Ports       : req [NUM_REQ] in  - active requests
//                ptr [IW]      in  - requester with highest priority
//                gnt [NUM_REQ] out - one-hot winner (all zero when no request)
//                idx [IW]      out - winner index (0 when no request)
//                any           out - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ = 2,
   localparam int IW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx,
   output logic               any
);

   always_comb begin
      int          cand;
      logic [IW-1:0] cand_idx;
      gnt      = '0;
      idx      = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IW'(cand);
         if (!any && req[cand_idx]) begin
            any           = 1'b1;
            gnt[cand_idx] = 1'b1;
            idx           = cand_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/handshake_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_arbiter
//  Description : Shares one downstream handshake resource between NUM_REQ
//                requesters. Round-robin arbitration, a single transaction
//                in flight, and an error response when the resource stays
//                silent for TIMEOUT cycles.
//  Ports       : clk                 in  - clock, rising edge
//                rst                 in  - asynchronous reset, active low
//                req_valid [NUM_REQ] in  - request word present on req_inf[i]
//                req_ready [NUM_REQ] out - request i accepted this cycle
//                req_inf   [NUM_REQ] ifc - port1 request in, port2 response out
//                rsp_valid [NUM_REQ] out - response available on req_inf[i]
//                rsp_ready [NUM_REQ] in  - requester i takes its response
//                rsp_err   [NUM_REQ] out - response is a timeout error
//                gnt_inf             ifc - port1 request out, port2 response in
//                gnt_valid           out - request valid toward the resource
//                gnt_ready           in  - resource accepts the request
//                gnt_rsp             in  - resource response strobe
//                busy                out - transaction in progress
//                cur_idx   [IW]      out - owner of the current transaction
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_arbiter
   import handshake_pkg::*;
#(
   parameter int WIDTH   = HS_WIDTH,
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 255,
   localparam int IW     = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   handshake.dir2             req_inf [NUM_REQ],
   output logic [NUM_REQ-1:0] rsp_valid,
   input  logic [NUM_REQ-1:0] rsp_ready,
   output logic [NUM_REQ-1:0] rsp_err,
   handshake.dir1             gnt_inf,
   output logic               gnt_valid,
   input  logic               gnt_ready,
   input  logic               gnt_rsp,
   output logic               busy,
   output logic [IW-1:0]      cur_idx
);

   localparam int CW = cnt_width(TIMEOUT);

   arb_state_t       state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    cur_idx_q, cur_idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] gnt_data_q, gnt_data_d;
   logic [WIDTH-1:0] rsp_data_q [NUM_REQ];
   logic [WIDTH-1:0] rsp_data_d [NUM_REQ];

   logic [WIDTH-1:0]   w_req_data [NUM_REQ];
   logic [NUM_REQ-1:0] w_pick_gnt;
   logic [IW-1:0]      w_pick_idx;
   logic               w_pick_any;
   logic               w_timeout;

   // Unpack the interface array so the request word can be selected by a
   // run-time index, and drive each response word from its own register.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_req_data[gi]     = req_inf[gi].port1;
      assign req_inf[gi].port2  = rsp_data_q[gi];
   end

   assign gnt_inf.port1 = gnt_data_q;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (w_pick_gnt),
      .idx (w_pick_idx),
      .any (w_pick_any)
   );

   assign w_timeout = (cnt_q == CW'(TIMEOUT - 1));

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ARB_IDLE;
         ptr_q      <= '0;
         cur_idx_q  <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         gnt_data_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            rsp_data_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cur_idx_q  <= cur_idx_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         gnt_data_q <= gnt_data_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:  if (w_pick_any)                state_d = ARB_ISSUE;
         ARB_ISSUE: if (gnt_ready)                 state_d = ARB_WAIT;
         ARB_WAIT:  if (gnt_rsp || w_timeout)      state_d = ARB_RESP;
         ARB_RESP:  if (rsp_ready[cur_idx_q])      state_d = ARB_IDLE;
         default:                                  state_d = ARB_IDLE;
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_comb begin
      ptr_d      = ptr_q;
      cur_idx_d  = cur_idx_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      gnt_data_d = gnt_data_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         ARB_IDLE: begin
            if (w_pick_any) begin
               gnt_data_d = w_req_data[w_pick_idx];
               cur_idx_d  = w_pick_idx;
            end
         end
         ARB_ISSUE: begin
            if (gnt_ready) begin
               cnt_d = '0;
            end
         end
         ARB_WAIT: begin
            // A response arriving in the timeout cycle still counts as good.
            if (gnt_rsp) begin
               rsp_data_d[cur_idx_q] = gnt_inf.port2;
               err_d                 = 1'b0;
            end else if (w_timeout) begin
               rsp_data_d[cur_idx_q] = '0;
               err_d                 = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ARB_RESP: begin
            if (rsp_ready[cur_idx_q]) begin
               ptr_d = (cur_idx_q == IW'(NUM_REQ - 1)) ? '0 : cur_idx_q + IW'(1);
            end
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_err   = '0;
      gnt_valid = 1'b0;
      busy      = (state_q != ARB_IDLE);
      cur_idx   = cur_idx_q;
      // The accept strobe is combinational from req_valid, so hold it low
      // while reset is asserted rather than relying on the state alone.
      if (state_q == ARB_IDLE && rst) begin
         req_ready = w_pick_gnt;
      end
      if (state_q == ARB_ISSUE) begin
         gnt_valid = 1'b1;
      end
      if (state_q == ARB_RESP) begin
         rsp_valid[cur_idx_q] = 1'b1;
         rsp_err[cur_idx_q]   = err_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_handshake_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_handshake_arbiter
//  Description : Self-checking bench for handshake_arbiter with two
//                requesters and TIMEOUT=4. Expected responses are queued when
//                a request is driven and popped when the response appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_arbiter;

   typedef struct packed {
      logic [0:0]  idx;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic        gnt_valid, gnt_ready, gnt_rsp, busy;
   logic [0:0]  cur_idx;
   logic [31:0] rsp_word [2];

   exp_t sb [$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   handshake #(.WIDTH(32)) req_if [2] ();
   handshake #(.WIDTH(32)) gnt_if ();

   assign rsp_word[0] = req_if[0].port2;
   assign rsp_word[1] = req_if[1].port2;

   handshake_arbiter #(
      .WIDTH   (32),
      .NUM_REQ (2),
      .TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_inf   (req_if),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_err   (rsp_err),
      .gnt_inf   (gnt_if),
      .gnt_valid (gnt_valid),
      .gnt_ready (gnt_ready),
      .gnt_rsp   (gnt_rsp),
      .busy      (busy),
      .cur_idx   (cur_idx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 2'b00;
      gnt_ready = 1'b0;
      gnt_rsp   = 1'b0;
      req_if[0].port1 = 32'h1111_1111;
      req_if[1].port1 = 32'h2222_2222;
      gnt_if.port2    = 32'h3333_3333;
      tick();
      tick();
      at_neg();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      n_checks++; if (rsp_valid !== 2'b00 || rsp_err !== 2'b00) begin n_fail++; $display("FAIL reset_rsp: valid %b err %b want 00 00", rsp_valid, rsp_err); end
      n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_valid: got %b want 0", gnt_valid); end
      n_checks++; if (cur_idx !== 1'b0) begin n_fail++; $display("FAIL reset_cur_idx: got %0d want 0", cur_idx); end
      n_checks++; if (gnt_if.port1 !== 32'h0) begin n_fail++; $display("FAIL reset_gnt_port1: got %h want 0", gnt_if.port1); end
      n_checks++; if (rsp_word[0] !== 32'h0 || rsp_word[1] !== 32'h0) begin n_fail++; $display("FAIL reset_port2: got %h %h want 0 0", rsp_word[0], rsp_word[1]); end
      req_valid = 2'b00;
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      req_valid = 2'b01;
      req_if[0].port1 = 32'hDEAD_BEEF;
      gnt_ready = 1'b1;
      sb.push_back('{idx: 1'b0, data: 32'h1234_5678, err: 1'b0});
      at_neg();
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_req_ready: got %b want 01", req_ready); end
      tick();
      req_valid = 2'b00;
      at_neg();
      n_checks++; if (gnt_valid !== 1'b1 || gnt_if.port1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_issue: valid %b data %h want 1 deadbeef", gnt_valid, gnt_if.port1); end
      tick();
      gnt_rsp = 1'b1;
      gnt_if.port2 = 32'h1234_5678;
      tick();
      gnt_rsp = 1'b0;
      gnt_if.port2 = 32'hFFFF_0000;
      at_neg();
      e = sb.pop_front();
      n_checks++; if (rsp_valid !== (2'b01 << e.idx) || rsp_word[e.idx] !== e.data || rsp_err[e.idx] !== e.err) begin n_fail++; $display("FAIL single_rsp: valid %b data %h err %b want %b %h %b", rsp_valid, rsp_word[e.idx], rsp_err[e.idx], 2'b01 << e.idx, e.data, e.err); end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      at_neg();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy %b want 0", busy); end
   endtask

   task automatic test_contention();
      logic [0:0]  tb_rr;
      logic [31:0] word;
      pulse_reset();
      tb_rr = 1'b0;
      req_valid = 2'b11;
      gnt_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         req_if[0].port1 = 32'hA000_0000 + t;
         req_if[1].port1 = 32'hB000_0000 + t;
         word = 32'hC000_0000 + t;
         sb.push_back('{idx: tb_rr, data: word, err: 1'b0});
         at_neg();
         n_checks++; if (req_ready !== (2'b01 << tb_rr) || $countones(req_ready) > 1) begin n_fail++; $display("FAIL contention_grant[%0d]: got %b want %b", t, req_ready, 2'b01 << tb_rr); end
         tick();
         at_neg();
         n_checks++; if (cur_idx !== tb_rr || gnt_if.port1 !== (tb_rr ? 32'hB000_0000 + t : 32'hA000_0000 + t)) begin n_fail++; $display("FAIL contention_issue[%0d]: idx %0d data %h want idx %0d", t, cur_idx, gnt_if.port1, tb_rr); end
         n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL contention_busy_ready[%0d]: got %b want 00", t, req_ready); end
         tick();
         gnt_rsp = 1'b1;
         gnt_if.port2 = word;
         tick();
         gnt_rsp = 1'b0;
         at_neg();
         e = sb.pop_front();
         n_checks++; if (rsp_valid !== (2'b01 << e.idx) || rsp_word[e.idx] !== e.data || rsp_err !== 2'b00) begin n_fail++; $display("FAIL contention_rsp[%0d]: valid %b data %h err %b want %b %h 00", t, rsp_valid, rsp_word[e.idx], rsp_err, 2'b01 << e.idx, e.data); end
         rsp_ready = 2'b11;
         tick();
         rsp_ready = 2'b00;
         tb_rr = ~tb_rr;
      end
      req_valid = 2'b00;
   endtask

   task automatic test_timeout();
      req_valid = 2'b10;
      req_if[1].port1 = 32'hCAFE_F00D;
      gnt_ready = 1'b1;
      sb.push_back('{idx: 1'b1, data: 32'h0, err: 1'b1});
      at_neg();
      n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL timeout_grant: got %b want 10", req_ready); end
      tick();
      req_valid = 2'b00;
      tick();
      gnt_if.port2 = 32'h5555_AAAA;
      for (int c = 0; c < 4; c++) begin
         at_neg();
         n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_wait[%0d]: valid %b busy %b want 00 1", c, rsp_valid, busy); end
         tick();
      end
      at_neg();
      e = sb.pop_front();
      n_checks++; if (rsp_valid !== (2'b01 << e.idx) || rsp_err !== (2'b01 << e.idx) || rsp_word[e.idx] !== e.data) begin n_fail++; $display("FAIL timeout_rsp: valid %b err %b data %h want 10 10 %h", rsp_valid, rsp_err, rsp_word[e.idx], e.data); end
      rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;
      req_valid = 2'b11;
      at_neg();
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL timeout_rr_advance: got %b want 01", req_ready); end
      req_valid = 2'b00;
      tick();
   endtask

   task automatic test_backpressure();
      req_valid = 2'b01;
      req_if[0].port1 = 32'h0BAD_F00D;
      gnt_ready = 1'b1;
      sb.push_back('{idx: 1'b0, data: 32'h7777_1111, err: 1'b0});
      tick();
      req_valid = 2'b00;
      tick();
      gnt_rsp = 1'b1;
      gnt_if.port2 = 32'h7777_1111;
      tick();
      gnt_rsp = 1'b0;
      gnt_if.port2 = 32'h0;
      req_valid = 2'b10;
      rsp_ready = 2'b00;
      e = sb.pop_front();
      for (int c = 0; c < 10; c++) begin
         at_neg();
         n_checks++; if (rsp_valid !== 2'b01 || rsp_word[0] !== e.data || rsp_err !== 2'b00) begin n_fail++; $display("FAIL bp_hold[%0d]: valid %b data %h err %b want 01 %h 00", c, rsp_valid, rsp_word[0], rsp_err, e.data); end
         n_checks++; if (busy !== 1'b1 || req_ready !== 2'b00 || gnt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_grant[%0d]: busy %b ready %b gnt %b want 1 00 0", c, busy, req_ready, gnt_valid); end
         tick();
      end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      at_neg();
      n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_pending_grant: got %b want 10", req_ready); end
   endtask

   task automatic test_reset_wait();
      req_if[1].port1 = 32'h4444_0001;
      tick();
      req_valid = 2'b00;
      gnt_ready = 1'b1;
      tick();
      at_neg();
      n_checks++; if (busy !== 1'b1 || cur_idx !== 1'b1) begin n_fail++; $display("FAIL rstwait_pre: busy %b idx %0d want 1 1", busy, cur_idx); end
      tick();
      #2;
      rst = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0 || gnt_valid !== 1'b0 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rstwait_async: busy %b gnt %b rsp %b want 0 0 00", busy, gnt_valid, rsp_valid); end
      tick();
      rst = 1'b1;
      gnt_rsp = 1'b1;
      gnt_if.port2 = 32'h9999_9999;
      for (int c = 0; c < 3; c++) begin
         at_neg();
         n_checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rstwait_dropped[%0d]: busy %b rsp %b want 0 00", c, busy, rsp_valid); end
         tick();
      end
      gnt_rsp = 1'b0;
      req_valid = 2'b11;
      at_neg();
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstwait_rr_zero: got %b want 01", req_ready); end
      req_valid = 2'b00;
      tick();
   endtask

   task automatic test_timeout_boundary();
      req_valid = 2'b01;
      req_if[0].port1 = 32'h1111_2222;
      gnt_ready = 1'b1;
      gnt_if.port2 = 32'h0;
      sb.push_back('{idx: 1'b0, data: 32'hA5A5_5A5A, err: 1'b0});
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      tick();
      tick();
      at_neg();
      n_checks++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL boundary_wait: valid %b busy %b want 00 1", rsp_valid, busy); end
      gnt_rsp = 1'b1;
      gnt_if.port2 = 32'hA5A5_5A5A;
      tick();
      gnt_rsp = 1'b0;
      gnt_if.port2 = 32'h0;
      at_neg();
      e = sb.pop_front();
      n_checks++; if (rsp_valid !== (2'b01 << e.idx) || rsp_err !== 2'b00 || rsp_word[e.idx] !== e.data) begin n_fail++; $display("FAIL boundary_rsp: valid %b err %b data %h want 01 00 %h", rsp_valid, rsp_err, rsp_word[e.idx], e.data); end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      at_neg();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL boundary_idle: busy %b want 0", busy); end
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_timeout();
      test_backpressure();
      test_reset_wait();
      test_timeout_boundary();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
